mant_add_arbiter: RTL and testbench
===================================

// Module: mant_add_arbiter
// PURPOSE
//  Shares one MatissaAdder48 instance (combinational, 48-bit [55:8] carry-select adder) between
//  N_REQ requesters (multiplier lanes / accumulator paths) with round-robin arbitration.
//  Each accepted op is added in the grant cycle and registered into a DEPTH-entry output FIFO.
//  Results return in grant order, tagged with requester id and user tag. Supports split mode via ct.
// PARAMETERS
//  N_REQ   2  number of requesters (2..8)
//  TAG_W   4  user tag width, passed through unchanged
//  DEPTH   2  output FIFO entries (2..4)
//  ID_W    $clog2(N_REQ)  derived, do not override
// PORTS
//  clk        in   1            rising-edge clock
//  rst_n      in   1            synchronous reset, active low
//  req_valid  in   N_REQ        per-requester op valid
//  req_ready  out  N_REQ        one-hot grant; accept = req_valid[i] & req_ready[i]
//  req_a      in   N_REQ*48     operand A, requester i in [48*i+47:48*i] (maps to A[55:8])
//  req_b      in   N_REQ*48     operand B, same packing
//  req_split  in   N_REQ        1 = split add (drives ct)
//  req_tag    in   N_REQ*TAG_W  user tag
//  rsp_valid  out  1            result valid (FIFO head)
//  rsp_ready  in   1            consumer accepts head
//  rsp_sum    out  48           result
//  rsp_id     out  ID_W         index of originating requester
//  rsp_tag    out  TAG_W        tag of originating op
//  busy       out  1            FIFO non-empty
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): FIFO count=0, rd/wr ptrs=0, rr pointer last=N_REQ-1;
//    rsp_valid=0, busy=0, req_ready=0 during reset; rsp_sum/id/tag=0.
//  - Arbitration (comb): if count<DEPTH, grant lowest i in order last+1, last+2, ... (mod N_REQ)
//    with req_valid[i]=1; req_ready=onehot(i). count==DEPTH -> req_ready=0 even if rsp_ready=1
//    (no same-cycle pop-through on full). No valid -> req_ready=0. At most one grant per cycle.
//  - last updates to granted i only on accept; unchanged otherwise (idle cycles keep fairness).
//  - Datapath: granted operands muxed to adder, ct=req_split[i]. split=0: sum=(A+B) mod 2^48.
//    split=1: sum[47:20]=(A[47:20]+B[47:20]) mod 2^28, sum[19:0]=(A[19:0]+B[19:0]) mod 2^20;
//    no carry crosses bit 19->20. Carry out of bit 47 discarded in both modes.
//  - Latency: accept at edge t -> entry written at t; if FIFO was empty, rsp_valid=1 after edge t
//    (1 cycle). Output driven directly from FIFO head register, no comb path req->rsp.
//  - Pop when rsp_valid & rsp_ready. Push and pop same cycle: count unchanged, both ptrs advance.
//  - Pointers wrap modulo DEPTH. rsp_* hold stable while rsp_valid=1 & rsp_ready=0.
//  - Requester inputs are sampled only in their accept cycle; changes while not granted ignored.
//  - Reset mid-operation: all FIFO contents dropped, no rsp issued for in-flight ops.
// TESTING
//  1 Single op: req0 a=48'h0000_0FFF_FFFF, b=1, split=0, tag=3 -> next cycle rsp_valid,
//    sum=48'h0000_1000_0000, id=0, tag=3.
//  2 Split: a=48'h0000_000F_FFFF, b=1, split=1 -> sum=48'h0; same with split=0 -> 48'h0000_0010_0000.
//  3 Round-robin: N_REQ=2, both valid continuously, rsp_ready=1 -> grants 0,1,0,1...
//    (first grant 0 after reset); rsp_id alternates.
//  4 Backpressure: rsp_ready=0, req0 valid 4 cycles -> exactly DEPTH accepts, then req_ready=0;
//    release rsp_ready -> results drained in order, ops 3,4 accepted afterwards, none lost.
//  5 Overflow wrap: a=b=48'h8000_0000_0000, split=0 -> sum=0; split=1 -> sum=0.
//  6 Reset with 2 entries queued -> rsp_valid=0 next cycle, no stale result after reset release.

Source files
------------

// File: rtl/mant_add_arbiter.sv
// ---------------------------------------------------------------------------
// mant_add_arbiter
//   One shared 48-bit carry-select mantissa adder with round-robin access.
//   N_REQ requesters compete for the adder. The winner's operands are added
//   in its grant cycle, and the result goes into a DEPTH-entry output FIFO.
//   Results leave in grant order, tagged with the requester id and user tag.
//   In split mode (ct=1) the adder works as two independent fields,
//   [47:20] and [19:0], and no carry passes between them.
//
// Ports
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   req_valid/req_ready   per-requester handshake, req_ready is a one-hot grant
//   req_a/req_b           packed 48-bit operands, requester i at [48*i +: 48]
//   req_split             per-requester split-mode select
//   req_tag               packed user tags, requester i at [TAG_W*i +: TAG_W]
//   rsp_valid/rsp_ready   result handshake at the FIFO head
//   rsp_sum/rsp_id/rsp_tag  head entry contents
//   busy                  FIFO non-empty
// ---------------------------------------------------------------------------

// Carry-select adder covering mantissa bits [55:8], seen here as [47:0].
// Bits [19:0] use a ripple add. The upper 28 bits are seven 4-bit
// carry-select blocks. ct=1 blocks the carry from bit 19 into bit 20.
module matissa_adder48 (
  input  logic [47:0] a,
  input  logic [47:0] b,
  input  logic        ct,
  output logic [47:0] sum
);
  logic        c20;
  logic [6:0]  blk_cin;

  assign {c20, sum[19:0]} = {1'b0, a[19:0]} + {1'b0, b[19:0]};
  assign blk_cin[0] = ct ? 1'b0 : c20;

  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_blk
      localparam int LSB = 20 + 4 * gi;
      if (gi < 6) begin : g_mid
        logic [4:0] s0;
        logic [4:0] s1;
        assign s0 = {1'b0, a[LSB +: 4]} + {1'b0, b[LSB +: 4]};
        assign s1 = {1'b0, a[LSB +: 4]} + {1'b0, b[LSB +: 4]} + 5'd1;
        assign sum[LSB +: 4]  = blk_cin[gi] ? s1[3:0] : s0[3:0];
        assign blk_cin[gi+1]  = blk_cin[gi] ? s1[4]   : s0[4];
      end else begin : g_top
        // The carry out of bit 47 is dropped, so the top block is 4 bits wide.
        logic [3:0] t0;
        logic [3:0] t1;
        assign t0 = a[LSB +: 4] + b[LSB +: 4];
        assign t1 = a[LSB +: 4] + b[LSB +: 4] + 4'd1;
        assign sum[LSB +: 4] = blk_cin[gi] ? t1 : t0;
      end
    end
  endgenerate
endmodule

module mant_add_arbiter #(
  parameter int N_REQ = 2,
  parameter int TAG_W = 4,
  parameter int DEPTH = 2,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*48-1:0]    req_a,
  input  logic [N_REQ*48-1:0]    req_b,
  input  logic [N_REQ-1:0]       req_split,
  input  logic [N_REQ*TAG_W-1:0] req_tag,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [47:0]            rsp_sum,
  output logic [ID_W-1:0]        rsp_id,
  output logic [TAG_W-1:0]       rsp_tag,
  output logic                   busy
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0] count_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [ID_W-1:0]  last_reg;

  logic [47:0]      sum_mem [DEPTH];
  logic [ID_W-1:0]  id_mem  [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];

  logic [N_REQ-1:0] grant_oh;
  logic             grant_any;
  logic [ID_W-1:0]  grant_idx;
  logic [47:0]      a_sel;
  logic [47:0]      b_sel;
  logic             split_sel;
  logic [TAG_W-1:0] tag_sel;
  logic [47:0]      sum_next;
  int               rr_idx;

  logic push;
  logic pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Round-robin search starts just after the last accepted requester.
  // A full FIFO blocks every grant, even when the head pops this cycle,
  // so req_ready never depends on rsp_ready.
  always_comb begin
    grant_oh  = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    a_sel     = '0;
    b_sel     = '0;
    split_sel = 1'b0;
    tag_sel   = '0;
    rr_idx    = 0;
    if (rst_n && (count_reg < CNT_W'(DEPTH))) begin
      for (int k = 1; k <= N_REQ; k++) begin
        rr_idx = int'(last_reg) + k;
        if (rr_idx >= N_REQ) rr_idx = rr_idx - N_REQ;
        if (!grant_any && req_valid[rr_idx]) begin
          grant_any        = 1'b1;
          grant_oh[rr_idx] = 1'b1;
          grant_idx        = ID_W'(rr_idx);
          a_sel            = req_a[rr_idx*48 +: 48];
          b_sel            = req_b[rr_idx*48 +: 48];
          split_sel        = req_split[rr_idx];
          tag_sel          = req_tag[rr_idx*TAG_W +: TAG_W];
        end
      end
    end
  end

  matissa_adder48 u_adder (
    .a   (a_sel),
    .b   (b_sel),
    .ct  (split_sel),
    .sum (sum_next)
  );

  assign req_ready = grant_oh;
  assign push      = grant_any;
  assign rsp_valid = (count_reg != '0);
  assign busy      = rsp_valid;
  assign pop       = rsp_valid & rsp_ready;

  assign rsp_sum = sum_mem[rd_ptr_reg];
  assign rsp_id  = id_mem[rd_ptr_reg];
  assign rsp_tag = tag_mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      last_reg   <= ID_W'(N_REQ - 1);
      // Storage is cleared so the head reads as zero after reset.
      for (int i = 0; i < DEPTH; i++) begin
        sum_mem[i] <= '0;
        id_mem[i]  <= '0;
        tag_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        sum_mem[wr_ptr_reg] <= sum_next;
        id_mem[wr_ptr_reg]  <= grant_idx;
        tag_mem[wr_ptr_reg] <= tag_sel;
        wr_ptr_reg          <= ptr_inc(wr_ptr_reg);
        last_reg            <= grant_idx;
      end
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: tb/tb_mant_add_arbiter.sv
module tb_mant_add_arbiter;
  localparam int N_REQ = 2;
  localparam int TAG_W = 4;
  localparam int DEPTH = 2;
  localparam int ID_W  = 1;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*48-1:0]    req_a;
  logic [N_REQ*48-1:0]    req_b;
  logic [N_REQ-1:0]       req_split;
  logic [N_REQ*TAG_W-1:0] req_tag;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [47:0]            rsp_sum;
  logic [ID_W-1:0]        rsp_id;
  logic [TAG_W-1:0]       rsp_tag;
  logic                   busy;

  always #5 clk = ~clk;

  mant_add_arbiter #(.N_REQ(N_REQ), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_split(req_split), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
    .rsp_id(rsp_id), .rsp_tag(rsp_tag), .busy(busy)
  );

  typedef struct {
    int          r;
    logic [47:0] a;
    logic [47:0] b;
    logic        split;
    logic [3:0]  tag;
    logic [47:0] exp;
  } vec_t;

  typedef struct {
    logic [47:0] sum;
    logic [0:0]  id;
    logic [3:0]  tag;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  exp_t q[$];
  logic [N_REQ-1:0] last_ready;
  int   n_acc;
  int   n_pop;
  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  function automatic logic [47:0] ref_add(input logic [47:0] a, input logic [47:0] b,
                                          input logic split);
    logic [27:0] hi;
    logic [19:0] lo;
    if (split) begin
      hi = a[47:20] + b[47:20];
      lo = a[19:0] + b[19:0];
      return {hi, lo};
    end
    return a + b;
  endfunction

  // One clock: inputs were set at the falling edge. Check the head against
  // the scoreboard, note accepts and pops, then advance to the next falling edge.
  task automatic step();
    logic do_pop;
    exp_t e;
    #1;
    chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, q.size() != 0});
    chk("busy", {63'd0, busy}, {63'd0, q.size() != 0});
    chk("grant_onehot", 64'($countones(req_ready) <= 1), 64'd1);
    if (rsp_valid && q.size() > 0) begin
      chk("rsp_sum", {16'd0, rsp_sum}, {16'd0, q[0].sum});
      chk("rsp_id", {63'd0, rsp_id}, {63'd0, q[0].id});
      chk("rsp_tag", {60'd0, rsp_tag}, {60'd0, q[0].tag});
    end
    last_ready = req_ready;
    do_pop = rsp_valid & rsp_ready;
    n_acc = 0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        e.sum = ref_add(req_a[48*i +: 48], req_b[48*i +: 48], req_split[i]);
        e.id  = 1'(i);
        e.tag = req_tag[TAG_W*i +: TAG_W];
        n_acc++;
      end
    end
    @(posedge clk);
    if (do_pop && q.size() > 0) begin
      void'(q.pop_front());
      n_pop++;
    end
    if (n_acc > 0) q.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
  endtask

  task automatic set_req(input int r, input logic [47:0] a, input logic [47:0] b,
                         input logic split, input logic [3:0] tag);
    req_a[48*r +: 48]         = a;
    req_b[48*r +: 48]         = b;
    req_split[r]              = split;
    req_tag[TAG_W*r +: TAG_W] = tag;
  endtask

  initial begin
    int next_op;
    int cyc;
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_split = '0;
    req_tag = '0; rsp_ready = 1'b0; n_pop = 0;

    vecs[0] = '{0, 48'h0000_0FFF_FFFF, 48'h1, 1'b0, 4'h3, 48'h0000_1000_0000};
    vecs[1] = '{0, 48'h0000_000F_FFFF, 48'h1, 1'b1, 4'h1, 48'h0};
    vecs[2] = '{1, 48'h0000_000F_FFFF, 48'h1, 1'b0, 4'h2, 48'h0000_0010_0000};
    vecs[3] = '{0, 48'h8000_0000_0000, 48'h8000_0000_0000, 1'b0, 4'h4, 48'h0};
    vecs[4] = '{1, 48'h8000_0000_0000, 48'h8000_0000_0000, 1'b1, 4'h5, 48'h0};
    vecs[5] = '{0, 48'h0000_0FFF_FFFF, 48'h1, 1'b1, 4'h6, 48'h0000_0FF0_0000};
    vecs[6] = '{1, 48'hFFFF_FFFF_FFFF, 48'h1, 1'b1, 4'h7, 48'hFFFF_FFF0_0000};
    vecs[7] = '{0, 48'h1234_5678_9ABC, 48'h1111_1111_1111, 1'b0, 4'h8, 48'h2345_6789_ABCD};
    vecs[8] = '{1, 48'h0000_0008_0000, 48'h0000_0008_0000, 1'b1, 4'hF, 48'h0};
    vecs[9] = '{0, 48'h0FFF_FFF0_0000, 48'h0000_0010_0000, 1'b1, 4'h9, 48'h1000_0000_0000};

    // Reset state with a requester asserting valid.
    req_valid = 2'b01;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_req_ready", {62'd0, req_ready}, 64'd0);
    chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_rsp_sum", {16'd0, rsp_sum}, 64'd0);
    chk("reset_rsp_id_tag", {59'd0, rsp_id, rsp_tag}, 64'd0);
    req_valid = '0;
    rst_n = 1'b1;
    @(negedge clk);

    // Single ops from the table, one result per op, latency one cycle.
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_req(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].split, vecs[i].tag);
      req_valid = '0;
      req_valid[vecs[i].r] = 1'b1;
      step();
      chk($sformatf("vec%0d_accept", i), {62'd0, last_ready}, 64'd1 << vecs[i].r);
      req_valid = '0;
      #1;
      chk($sformatf("vec%0d_valid", i), {63'd0, rsp_valid}, 64'd1);
      chk($sformatf("vec%0d_sum", i), {16'd0, rsp_sum}, {16'd0, vecs[i].exp});
      chk($sformatf("vec%0d_id", i), {63'd0, rsp_id}, 64'(vecs[i].r));
      chk($sformatf("vec%0d_tag", i), {60'd0, rsp_tag}, {60'd0, vecs[i].tag});
      step();
    end

    // Round-robin: both requesters valid, grants start at 0 and alternate.
    do_reset();
    rsp_ready = 1'b1;
    set_req(0, 48'h10, 48'h1, 1'b0, 4'hA);
    set_req(1, 48'h20, 48'h2, 1'b0, 4'hB);
    req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("rr_grant%0d", i), {62'd0, last_ready}, (i % 2 == 0) ? 64'd1 : 64'd2);
    end
    req_valid = '0;
    step();
    step();

    // Backpressure: the FIFO fills to DEPTH, then the release drains in order.
    do_reset();
    rsp_ready = 1'b0;
    n_pop = 0;
    next_op = 0;
    for (int c = 0; c < 4; c++) begin
      set_req(0, 48'h100 + 48'(next_op), 48'h7, 1'b0, 4'(next_op + 1));
      req_valid = 2'b01;
      step();
      if (last_ready[0]) next_op++;
      if (c >= 2) chk($sformatf("bp_full_ready%0d", c), {62'd0, last_ready}, 64'd0);
    end
    chk("bp_accepts", 64'(next_op), 64'(DEPTH));
    rsp_ready = 1'b1;
    set_req(0, 48'h100 + 48'(next_op), 48'h7, 1'b0, 4'(next_op + 1));
    step();
    chk("bp_no_popthrough", {62'd0, last_ready}, 64'd0);
    cyc = 0;
    while ((next_op < 4 || q.size() != 0) && cyc < 20) begin
      if (next_op < 4) begin
        set_req(0, 48'h100 + 48'(next_op), 48'h7, 1'b0, 4'(next_op + 1));
        req_valid = 2'b01;
      end else begin
        req_valid = '0;
      end
      step();
      if (last_ready[0]) next_op++;
      cyc++;
    end
    chk("bp_all_accepted", 64'(next_op), 64'd4);
    chk("bp_all_drained", 64'(n_pop), 64'd4);

    // Reset with two entries queued: contents dropped, no stale result.
    do_reset();
    rsp_ready = 1'b0;
    set_req(0, 48'h55, 48'h1, 1'b0, 4'h5);
    set_req(1, 48'h66, 48'h1, 1'b0, 4'h6);
    req_valid = 2'b11;
    step();
    step();
    chk("rst_busy_before", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_req_ready_low", {62'd0, req_ready}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_rsp_sum", {16'd0, rsp_sum}, 64'd0);
    q.delete();
    req_valid = '0;
    rsp_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
